// File: rtl/serial_8bit_subtractor_if.sv
// Operand/result handshake bundle for serial_8bit_subtractor.
// ovf exists only when SUB_OVERFLOW_EN is defined.
interface serial_8bit_subtractor_if;
  localparam int unsigned W = 8;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
`ifdef SUB_OVERFLOW_EN
    , ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
`ifdef SUB_OVERFLOW_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_8bit_subtractor.sv
// Bit-serial 8-bit subtractor (a - b - bin), LSB-first, one bit per clock.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_8bit_subtractor (
  input  logic                      clk,
  input  logic                      rst,
  serial_8bit_subtractor_if.slave   bus
);
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          in_ready_nxt;
  logic          out_valid_nxt;
  logic          busy_nxt;

  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  diff_sr;
  logic [CW-1:0] cnt;
  logic          br;
  logic          bout_q;

  logic          accept;
  logic          last_bit;
  logic          d_bit;
  logic          br_nxt;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_bit = (state == RUN) && (cnt == CW'(W - 1));
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Output decode, taken from the next state so the flags come out registered
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    case (state_nxt)
      IDLE:    in_ready_nxt  = 1'b1;
      RUN:     busy_nxt      = 1'b1;
      DONE:    out_valid_nxt = 1'b1;
      default: in_ready_nxt  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Serial datapath: operands shift right, difference bits enter at the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      br      <= 1'b0;
      bout_q  <= 1'b0;
    end else if (accept) begin
      a_sr    <= bus.a;
      b_sr    <= bus.b;
      br      <= bus.bin;
      diff_sr <= '0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sr    <= {1'b0, a_sr[W-1:1]};
      b_sr    <= {1'b0, b_sr[W-1:1]};
      diff_sr <= {d_bit, diff_sr[W-1:1]};
      br      <= br_nxt;
      cnt     <= cnt + CW'(1);
      if (last_bit) bout_q <= br_nxt;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic ovf_q;

  // Borrow into bit 7 vs borrow out of bit 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= br ^ br_nxt;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.diff      = diff_sr;
  assign bus.bout      = bout_q;
endmodule

// File: tb/tb_serial_8bit_subtractor.sv
// Self-checking bench for serial_8bit_subtractor: directed corner cases plus
// randomized operands against an arithmetic reference model.
module tb_serial_8bit_subtractor;
  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   cyc;
  int   last_accept;

  serial_8bit_subtractor_if bus ();

  serial_8bit_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int ur;
    int sr;
    logic [7:0] d;
    logic bo;
    logic ov;
    ur = int'(a) - int'(b) - int'(bin);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = 8'(ur);
    bo = (ur < 0);
    ov = (sr < -128) || (sr > 127);
    return {ov, bo, d};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  // One operation; hold = cycles out_ready stays low once the result is up.
  // Entered just after a rising edge; returns just after the edge that retires the result.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int hold, input bit check_ii, input string tag);
    logic [9:0] exp;
    int         cycles;
    int         busy_cnt;
    logic [7:0] d_hold;
    logic       b_hold;
    exp = model(a, b, bin);
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    if (check_ii) chk({tag, "_ii"}, 32'(cyc - last_accept), 32'd10);
    last_accept = cyc;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom);
    busy_cnt = int'(bus.busy);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (!bus.out_valid) busy_cnt += int'(bus.busy);
    end
    chk({tag, "_latency"}, 32'(cycles), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(exp[7:0]));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(exp[8]));
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[9]));
`endif
    d_hold = bus.diff;
    b_hold = bus.bout;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 1);
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({tag, "_bp_valid"},    32'(bus.out_valid), 32'd1);
      chk({tag, "_bp_in_ready"}, 32'(bus.in_ready),  32'd0);
      chk({tag, "_bp_diff"},     32'(bus.diff),      32'(d_hold));
      chk({tag, "_bp_bout"},     32'(bus.bout),      32'(b_hold));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle({tag, "_post"});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    int         wait_cnt;
    tests = 0; failed = 0; cyc = 0; last_accept = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_diff", 32'(bus.diff), 32'd0);
    chk("reset_bout", 32'(bus.bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'h50, 8'h20, 1'b0, 0, 1'b0, "basic");
    do_op(8'h00, 8'h01, 1'b0, 0, 1'b1, "under1");
    do_op(8'h00, 8'hFF, 1'b1, 0, 1'b1, "under2");
    do_op(8'h80, 8'h01, 1'b0, 0, 1'b1, "sovf");
    do_op(8'h7F, 8'hFF, 1'b0, 5, 1'b1, "backpr");
    do_op(8'h33, 8'h11, 1'b1, 0, 1'b0, "after_bp");
    do_op(8'hFF, 8'h00, 1'b1, 0, 1'b1, "b2b");

    // Abort after bit 4 has been resolved
    bus.a = 8'hA5; bus.b = 8'h3C; bus.bin = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle("abort");
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    @(negedge clk); rst = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wait_cnt += int'(bus.out_valid);
    end
    chk("abort_no_valid", 32'(wait_cnt), 32'd0);
    do_op(8'h0F, 8'h0F, 1'b0, 0, 1'b0, "post_abort");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      do_op(ra, rb, rbin, int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/serial_8bit_subtractor.md
# serial_8bit_subtractor

Bit-serial 8-bit subtractor with borrow-in and borrow-out. It is the inverse-operation companion to the registered 8-bit adder in the same arithmetic datapath. It accepts an operand pair through a valid/ready handshake, resolves one bit per clock LSB-first, and presents the registered difference and borrow through an output valid/ready handshake. It trades latency for a single-bit datapath and feeds the same downstream consumers as the adder.

## Interface

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept operands
- a  in  8  minuend
- b  in  8  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- diff  out  8  a − b − bin, modulo 256
- bout  out  1  borrow-out, 1 when a < b + bin (unsigned)
- busy  out  1  operation in progress (state RUN)
- ovf  out  1  signed overflow; present only with SUB_OVERFLOW_EN

## Operation

- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a clock edge: latch a, b and bin into shift registers, clear bit counter, clear diff shift register, enter RUN.
- RUN, one bit per cycle, with a0/b0 the current LSBs of the operand shift registers and br the running borrow (initialised from bin):
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into diff from the MSB side; the operand registers shift right; the counter increments.
  - After bit 7 is processed, the FSM captures bout = br_next and enters DONE.
- DONE:
  - out_valid=1. diff, bout and ovf are held stable.
  - On out_valid & out_ready: return to IDLE.
  - in_ready=0, so in_valid is ignored.
- in_valid is only sampled in IDLE. Operand inputs may change freely outside the accept edge.
- ovf = borrow into bit 7 XOR borrow out of bit 7. It is valid alongside diff.
- Reset mid-operation: the FSM returns to IDLE immediately and the partial result is discarded. No out_valid is produced for the aborted operation.

## Timing

- Reset values while rst is high:
  - in_ready=1, since the FSM is held in IDLE. No accept occurs while rst is high.
  - out_valid=0, busy=0, diff=8'h00, bout=0, ovf=0.
- Latency: with accept at edge E0, bits 0..7 are resolved at edges E1..E8, and out_valid rises after E8 (8 cycles).
- out_valid falls after the edge at which out_ready is sampled high. in_ready rises in the same cycle.
- Minimum initiation interval is 10 cycles when out_ready is held high: accept at E0, result handshake at E9, next accept at E10.
- busy is 1 exactly during the 8 RUN cycles.
- The diff/bout outputs are registered. Between the accept edge and E8 they show the in-progress shift register contents and are valid only while out_valid=1.

## Configuration

- SUB_OVERFLOW_EN defined:
  - The ovf port exists, along with the extra register that captures the borrow into bit 7.
- SUB_OVERFLOW_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan

- Reset: assert rst mid-cycle → out_valid=0, busy=0, diff=8'h00, bout=0, in_ready=1. After release, the first accept completes normally.
- Basic: a=8'h50, b=8'h20, bin=0 → diff=8'h30, bout=0, ovf=0. out_valid rises exactly 8 cycles after accept.
- Underflow: a=8'h00, b=8'h01, bin=0 → diff=8'hFF, bout=1, ovf=0. Then a=8'h00, b=8'hFF, bin=1 → diff=8'h00, bout=1, ovf=0.
- Signed overflow: a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → diff/bout stable and in_ready=0. An in_valid pulse during DONE is ignored. Release out_ready → IDLE on the next cycle, and the 10-cycle initiation interval is met back-to-back.
- Abort: assert rst during RUN after bit 4 → immediate return to IDLE with outputs zeroed and no out_valid. A new operation a=8'h0F, b=8'h0F → diff=8'h00, bout=0.
